// File: rtl/block_interleave_scheduler_pkg.sv
// Shared definitions for the block interleave scheduler and its deinterleave peer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package interleave_pkg;

    localparam int UNDERRUN_W = 16;

    // Slot index type at the default rotation size (3 channels).
    localparam int DEF_IIR = 3;
    typedef logic [$clog2(DEF_IIR)-1:0] slot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/block_interleave_scheduler_slot_rotator.sv
// Free-running modulo-IIR slot counter, shared by interleave and deinterleave sides.
// Latency: slot advances every clock; slot_last is combinational from slot.
// Backpressure: none, the rotation never stalls.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset (slot returns to 0)
//   slot        - current slot index 0..IIR-1
//   slot_last   - high when slot == IIR-1 (the next cycle is slot 0)
module slot_rotator #(
    parameter int IIR = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [$clog2(IIR)-1:0] slot,
    output logic                   slot_last
);
    localparam int              SW   = $clog2(IIR);
    localparam logic [SW-1:0]   LAST = SW'(IIR - 1);

    assign slot_last = (slot == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot <= '0;
        end else if (slot_last) begin
            slot <= '0;
        end else begin
            slot <= slot + SW'(1);
        end
    end

endmodule

// File: rtl/block_interleave_scheduler.sv
// Merges IIR per-channel sources into one slot-interleaved block of N samples per channel.
// Latency: 1 cycle from grant (in_valid & in_ready) to out_valid/data_out.
// Backpressure: none downstream; upstream waits for its slot, a missed slot is counted as underrun.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset (discards a partial block)
//   start             - pulse to begin one block; ignored unless idle
//   in_valid/data_in  - per-channel sample offer
//   in_ready          - combinational per-channel grant, at most one bit set
//   out_valid/data_out/out_set - registered interleaved sample and its slot index
//   block_start       - with the first out_valid of a block
//   block_done        - one cycle after the last sample of a block
//   busy              - block in progress
//   underrun_cnt      - saturating count of RUN slots whose channel had no sample
module block_interleave_scheduler
    import interleave_pkg::*;
#(
    parameter int BITS = 8,
    parameter int IIR  = 3,
    parameter int N    = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [IIR-1:0]             in_valid,
    input  logic [IIR-1:0][BITS-1:0]   data_in,
    output logic [IIR-1:0]             in_ready,
    output logic                       out_valid,
    output logic [BITS-1:0]            data_out,
    output logic [$clog2(IIR)-1:0]     out_set,
    output logic                       block_start,
    output logic                       block_done,
    output logic                       busy,
    output logic [UNDERRUN_W-1:0]      underrun_cnt
);
    localparam int            SW  = $clog2(IIR);
    localparam int            CW  = $clog2(N + 1);
    localparam logic [CW-1:0] N_C = CW'(N);

    sched_state_t    state;
    logic [SW-1:0]   slot;
    logic            slot_last;
    logic [CW-1:0]   cnt [IIR];

    logic [IIR-1:0]  chan_open;
    logic            all_full;
    logic            all_empty;
    logic [BITS-1:0] sel_data;
    logic            grant;
    logic            underrun;

    slot_rotator #(.IIR(IIR)) u_rot (
        .clk       (clk),
        .reset     (reset),
        .slot      (slot),
        .slot_last (slot_last)
    );

    // Per-channel status and the sample sitting on the current slot.
    always_comb begin
        chan_open = '0;
        all_full  = 1'b1;
        all_empty = 1'b1;
        sel_data  = '0;
        for (int c = 0; c < IIR; c++) begin
            chan_open[c] = (cnt[c] < N_C);
            if (cnt[c] != N_C) all_full  = 1'b0;
            if (cnt[c] != '0)  all_empty = 1'b0;
            if (slot == SW'(c)) sel_data = data_in[c];
        end
    end

    // Only the channel owning the current slot can be granted, and only while it still owes samples.
    always_comb begin
        in_ready = '0;
        for (int c = 0; c < IIR; c++) begin
            in_ready[c] = (state == RUN) && (slot == SW'(c)) && chan_open[c];
        end
    end

    assign grant    = |(in_valid & in_ready);
    assign underrun = |(~in_valid & in_ready);

    assign block_done = (state == DONE);
    assign busy       = (state != IDLE);

    // ALIGN waits for the last slot so the block always opens on slot 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start)     state <= ALIGN;
                ALIGN:   if (slot_last) state <= RUN;
                RUN:     if (all_full)  state <= DONE;
                DONE:                   state <= IDLE;
                default:                state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) begin
            for (int c = 0; c < IIR; c++) cnt[c] <= '0;
        end else begin
            for (int c = 0; c < IIR; c++) begin
                if (in_valid[c] && in_ready[c]) cnt[c] <= cnt[c] + CW'(1);
            end
        end
    end

    // Output stage. out_set holds across idle slots; block_start marks the grant
    // made while every channel count is still zero, i.e. the first of the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            data_out     <= '0;
            out_set      <= '0;
            block_start  <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            out_valid   <= grant;
            data_out    <= grant ? sel_data : '0;
            block_start <= grant && all_empty;
            if (grant) out_set <= slot;
            if (underrun && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_block_interleave_scheduler.sv
// Directed bench for block_interleave_scheduler (IIR=3, N=10, BITS=8).
// Latency: n/a.
// Backpressure: n/a.
module tb_block_interleave_scheduler;
    import interleave_pkg::*;

    localparam int BITS = 8;
    localparam int IIR  = 3;
    localparam int N    = 10;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [IIR-1:0]           in_valid;
    logic [IIR-1:0][BITS-1:0] data_in;
    logic [IIR-1:0]           in_ready;
    logic                     out_valid;
    logic [BITS-1:0]          data_out;
    slot_t                    out_set;
    logic                     block_start;
    logic                     block_done;
    logic                     busy;
    logic [15:0]              underrun_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Source state: next sample index per channel, channel 1 turn counter, hole window.
    int             k     [IIR];
    int             exp_k [IIR];
    int             ch1_turn;
    int             hole_lo;
    int             hole_hi;
    bit             all_off;
    logic [IIR-1:0] last_rdy;

    always #5 clk = ~clk;

    block_interleave_scheduler #(.BITS(BITS), .IIR(IIR), .N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .data_out     (data_out),
        .out_set      (out_set),
        .block_start  (block_start),
        .block_done   (block_done),
        .busy         (busy),
        .underrun_cnt (underrun_cnt)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no end, expected end");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel c offers sample c*16+k[c]; channel 1 goes quiet during turns hole_lo..hole_hi.
    task automatic drive();
        for (int c = 0; c < IIR; c++) begin
            in_valid[c] = !all_off && !(c == 1 && ch1_turn >= hole_lo && ch1_turn <= hole_hi);
            data_in[c]  = BITS'(c * 16 + k[c]);
        end
    endtask

    // One clock: note handshakes before the edge, sample/drive 1 time unit after it.
    task automatic cycle();
        logic [IIR-1:0] fire;
        fire     = in_valid & in_ready;
        last_rdy = in_ready;
        @(posedge clk);
        #1;
        for (int c = 0; c < IIR; c++) if (fire[c]) k[c]++;
        if (last_rdy[1]) ch1_turn++;
        start = 1'b0;
        drive();
    endtask

    task automatic begin_block();
        for (int c = 0; c < IIR; c++) begin
            k[c]     = 0;
            exp_k[c] = 0;
        end
        ch1_turn = 0;
        start    = 1'b1;
        drive();
    endtask

    // Runs one block from start to block_done and a few idle cycles after it.
    // strict: no underruns expected, so out_set must rotate 0,1,2 without gaps.
    // span: cycles from first to last out_valid inclusive.
    task automatic run_block(input string tag, input bit strict, input int span, input int busy_start_at);
        int  nout    = 0;
        int  first_t = -1;
        int  last_t  = -1;
        int  done_t  = -1;
        bit  pulsed  = 0;
        begin_block();
        for (int t = 0; t < 400 && done_t < 0; t++) begin
            cycle();
            if (out_valid) begin
                if (nout == 0) first_t = t;
                last_t = t;
                chk({tag, " block_start"}, block_start, nout == 0);
                chk({tag, " busy"}, busy, 1'b1);
                if (int'(out_set) < IIR) begin
                    chk({tag, " data"}, data_out, int'(out_set) * 16 + exp_k[out_set]);
                    exp_k[out_set]++;
                end else begin
                    chk({tag, " out_set range"}, out_set, 0);
                end
                if (strict) chk({tag, " out_set order"}, out_set, nout % IIR);
                nout++;
            end else begin
                chk({tag, " data idle zero"}, data_out, 0);
                chk({tag, " block_start idle"}, block_start, 0);
            end
            if (block_done) done_t = t;
            if (busy_start_at >= 0 && !pulsed && nout == busy_start_at) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
        end
        chk({tag, " block_done seen"}, done_t >= 0, 1'b1);
        chk({tag, " sample count"}, nout, N * IIR);
        chk({tag, " done after last"}, done_t - last_t, 1);
        chk({tag, " out_valid span"}, last_t - first_t + 1, span);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk({tag, " idle block_done"}, block_done, 0);
            chk({tag, " idle busy"}, busy, 0);
        end
    endtask

    initial begin
        int u;
        reset   = 1'b1;
        start   = 1'b0;
        all_off = 1'b0;
        hole_lo = 100;
        hole_hi = -1;
        ch1_turn = 0;
        for (int c = 0; c < IIR; c++) k[c] = 0;
        drive();
        repeat (3) @(posedge clk);
        #1;

        // 1: reset state, then idle for 50 cycles with the slot rotating.
        chk("rst out_valid", out_valid, 0);
        chk("rst data_out", data_out, 0);
        chk("rst out_set", out_set, 0);
        chk("rst block_start", block_start, 0);
        chk("rst block_done", block_done, 0);
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst underrun_cnt", underrun_cnt, 0);
        reset = 1'b0;
        chk("idle slot", dut.slot, 0);
        for (int i = 1; i <= 50; i++) begin
            cycle();
            chk("idle busy", busy, 0);
            chk("idle in_ready", in_ready, 0);
            chk("idle out_valid", out_valid, 0);
            chk("idle slot", dut.slot, i % IIR);
        end

        // 2: all channels always valid -> 30 back-to-back samples.
        run_block("blk", 1'b1, 30, -1);
        chk("blk underrun_cnt", underrun_cnt, 0);

        // 3: channel 1 misses its turns 2,3,4. It needs 13 turns, the last at
        // RUN slot 12*3+1 = 37, so out_valid spans slots 0..37 = 38 cycles.
        hole_lo = 2;
        hole_hi = 4;
        run_block("hole", 1'b0, 38, -1);
        chk("hole underrun_cnt", underrun_cnt, 3);
        chk("hole ch1 count", exp_k[1], N);
        hole_lo = 100;
        hole_hi = -1;

        // 4: start pulsed mid-block is dropped; a fresh start afterwards runs normally.
        run_block("busy_start", 1'b1, 30, 5);
        run_block("restart", 1'b1, 30, -1);

        // 5: reset after the 12th sample discards the block.
        begin_block();
        u = 0;
        for (int t = 0; t < 200 && u < 12; t++) begin
            cycle();
            if (out_valid) u++;
        end
        chk("abort reached 12", u, 12);
        reset = 1'b1;
        cycle();
        chk("abort out_valid", out_valid, 0);
        chk("abort data_out", data_out, 0);
        chk("abort out_set", out_set, 0);
        chk("abort block_start", block_start, 0);
        chk("abort block_done", block_done, 0);
        chk("abort busy", busy, 0);
        chk("abort in_ready", in_ready, 0);
        chk("abort underrun_cnt", underrun_cnt, 0);
        reset = 1'b0;
        run_block("after_abort", 1'b1, 30, -1);

        // 6: every channel silent; each RUN slot is an underrun until saturation.
        all_off = 1'b1;
        begin_block();
        u = 0;
        for (int t = 0; t < 70000 && u < 65534; t++) begin
            cycle();
            if (last_rdy != '0) u++;
        end
        chk("sat before", underrun_cnt, 65534);
        for (int t = 0; t < 100 && u < 65540; t++) begin
            cycle();
            if (last_rdy != '0) u++;
        end
        chk("sat held", underrun_cnt, 16'hFFFF);
        chk("sat busy", busy, 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("sat reset clear", underrun_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
